// File: rtl/sccb_init_seq_if.sv
// Byte-transaction handshake between the camera init sequencer (master)
// and the shared SCCB engine (slave).
interface sccb_init_seq_if;
    logic       sccb_req;
    logic       sccb_rw;
    logic [7:0] sccb_sub;
    logic [7:0] sccb_wdata;
    logic       sccb_ack;
    logic       sccb_nack;
    logic [7:0] sccb_rdata;

    modport master (
        output sccb_req, sccb_rw, sccb_sub, sccb_wdata,
        input  sccb_ack, sccb_nack, sccb_rdata
    );

    modport slave (
        input  sccb_req, sccb_rw, sccb_sub, sccb_wdata,
        output sccb_ack, sccb_nack, sccb_rdata
    );
endinterface

// File: rtl/sccb_init_seq.sv
// Camera power-up sequencer: timed PWDN/RST release, product-ID check over
// SCCB, then streams the register table with NACK retry and soft-reset settle.
module sccb_init_seq #(
    parameter int         TBL_LEN    = 168,
    parameter int         PWR_DLY    = 20000,
    parameter int         RST_DLY    = 20000,
    parameter int         WAKE_DLY   = 20000,
    parameter int         SETTLE_DLY = 50000,
    parameter logic [7:0] ID_H       = 8'h76,
    parameter logic [7:0] ID_L       = 8'h73,
    parameter int         MAX_RETRY  = 3
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   start,
    output logic                   OV_PWDN,
    output logic                   OV_RST,
    output logic [7:0]             tbl_addr,
    input  logic [15:0]            tbl_data,
    sccb_init_seq_if.master        sccb,
    output logic                   busy,
    output logic                   done,
    output logic                   id_ok,
    output logic                   err,
    output logic [1:0]             err_code
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] PWDN   = 4'd1;
    localparam logic [3:0] RST    = 4'd2;
    localparam logic [3:0] WAKE   = 4'd3;
    localparam logic [3:0] RD_H   = 4'd4;
    localparam logic [3:0] RD_L   = 4'd5;
    localparam logic [3:0] CHECK  = 4'd6;
    localparam logic [3:0] FETCH  = 4'd7;
    localparam logic [3:0] WR     = 4'd8;
    localparam logic [3:0] SETTLE = 4'd9;
    localparam logic [3:0] NEXT   = 4'd10;

    // Counter is loaded with N-1 so each timed state lasts exactly N cycles.
    localparam logic [23:0] PWR_LD    = 24'(PWR_DLY - 1);
    localparam logic [23:0] RST_LD    = 24'(RST_DLY - 1);
    localparam logic [23:0] WAKE_LD   = 24'(WAKE_DLY - 1);
    localparam logic [23:0] SETTLE_LD = 24'(SETTLE_DLY - 1);
    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);
    localparam logic [7:0]  LAST_IDX  = 8'(TBL_LEN - 1);

    logic [3:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic        fetch_ph_q, fetch_ph_d;
    logic        pwdn_q, pwdn_d;
    logic        ov_rst_q, ov_rst_d;
    logic [7:0]  tbl_addr_q, tbl_addr_d;
    logic        req_q, req_d;
    logic        rw_q, rw_d;
    logic [7:0]  sub_q, sub_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  id_h_q, id_h_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        soft_rst;

    assign soft_rst = (sub_q == 8'h12) && wdata_q[7];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        fetch_ph_d = fetch_ph_q;
        pwdn_d     = pwdn_q;
        ov_rst_d   = ov_rst_q;
        tbl_addr_d = tbl_addr_q;
        req_d      = req_q;
        rw_d       = rw_q;
        sub_d      = sub_q;
        wdata_d    = wdata_q;
        id_h_d     = id_h_q;
        done_d     = done_q;
        id_ok_d    = id_ok_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            IDLE: if (start) begin
                state_d    = PWDN;
                cnt_d      = PWR_LD;
                pwdn_d     = 1'b1;
                ov_rst_d   = 1'b0;
                tbl_addr_d = 8'd0;
                done_d     = 1'b0;
                id_ok_d    = 1'b0;
                err_d      = 1'b0;
                err_code_d = 2'b00;
            end
            PWDN: if (cnt_q == 24'd0) begin
                state_d = RST;
                cnt_d   = RST_LD;
                pwdn_d  = 1'b0;
            end else cnt_d = cnt_q - 24'd1;
            RST: if (cnt_q == 24'd0) begin
                state_d  = WAKE;
                cnt_d    = WAKE_LD;
                ov_rst_d = 1'b1;
            end else cnt_d = cnt_q - 24'd1;
            WAKE: if (cnt_q == 24'd0) begin
                state_d = RD_H;
                req_d   = 1'b1;
                rw_d    = 1'b1;
                sub_d   = 8'h0A;
                wdata_d = 8'h00;
                retry_d = 8'd0;
            end else cnt_d = cnt_q - 24'd1;
            RD_H, RD_L, WR: begin
                // req low here means we are in the mandatory one-cycle gap
                if (!req_q) req_d = 1'b1;
                else if (sccb.sccb_ack) begin
                    req_d = 1'b0;
                    if (sccb.sccb_nack) begin
                        if (retry_q < RETRY_LIM) retry_d = retry_q + 8'd1;
                        else begin
                            err_d      = 1'b1;
                            err_code_d = 2'b01;
                            state_d    = IDLE;
                        end
                    end else if (state_q == RD_H) begin
                        id_h_d  = sccb.sccb_rdata;
                        sub_d   = 8'h0B;
                        retry_d = 8'd0;
                        state_d = RD_L;
                    end else if (state_q == RD_L) begin
                        id_ok_d = (id_h_q == ID_H) && (sccb.sccb_rdata == ID_L);
                        state_d = CHECK;
                    end else if (soft_rst) begin
                        cnt_d   = SETTLE_LD;
                        state_d = SETTLE;
                    end else state_d = NEXT;
                end
            end
            CHECK: if (id_ok_q) begin
                state_d    = FETCH;
                fetch_ph_d = 1'b0;
            end else begin
                err_d      = 1'b1;
                err_code_d = 2'b10;
                state_d    = IDLE;
            end
            FETCH: if (!fetch_ph_q) fetch_ph_d = 1'b1;
            else begin
                state_d    = WR;
                fetch_ph_d = 1'b0;
                req_d      = 1'b1;
                rw_d       = 1'b0;
                sub_d      = tbl_data[15:8];
                wdata_d    = tbl_data[7:0];
                retry_d    = 8'd0;
            end
            SETTLE: if (cnt_q == 24'd0) state_d = NEXT;
            else cnt_d = cnt_q - 24'd1;
            NEXT: if (tbl_addr_q == LAST_IDX) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                tbl_addr_d = tbl_addr_q + 8'd1;
                fetch_ph_d = 1'b0;
                state_d    = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            cnt_q      <= 24'd0;
            retry_q    <= 8'd0;
            fetch_ph_q <= 1'b0;
            pwdn_q     <= 1'b1;
            ov_rst_q   <= 1'b0;
            tbl_addr_q <= 8'd0;
            req_q      <= 1'b0;
            rw_q       <= 1'b0;
            sub_q      <= 8'd0;
            wdata_q    <= 8'd0;
            id_h_q     <= 8'd0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            fetch_ph_q <= fetch_ph_d;
            pwdn_q     <= pwdn_d;
            ov_rst_q   <= ov_rst_d;
            tbl_addr_q <= tbl_addr_d;
            req_q      <= req_d;
            rw_q       <= rw_d;
            sub_q      <= sub_d;
            wdata_q    <= wdata_d;
            id_h_q     <= id_h_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign OV_PWDN         = pwdn_q;
    assign OV_RST          = ov_rst_q;
    assign tbl_addr        = tbl_addr_q;
    assign sccb.sccb_req   = req_q;
    assign sccb.sccb_rw    = rw_q;
    assign sccb.sccb_sub   = sub_q;
    assign sccb.sccb_wdata = wdata_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign id_ok           = id_ok_q;
    assign err             = err_q;
    assign err_code        = err_code_q;
endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: short delays, 3-entry table, scripted SCCB slave.
module tb_sccb_init_seq;
    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        start = 1'b0;
    logic        OV_PWDN, OV_RST, busy, done, id_ok, err;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic [1:0]  err_code;

    sccb_init_seq_if bus();

    sccb_init_seq #(
        .TBL_LEN(3), .PWR_DLY(4), .RST_DLY(4), .WAKE_DLY(4), .SETTLE_DLY(8),
        .ID_H(8'h76), .ID_L(8'h73), .MAX_RETRY(3)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start),
        .OV_PWDN(OV_PWDN), .OV_RST(OV_RST),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .sccb(bus),
        .busy(busy), .done(done), .id_ok(id_ok), .err(err), .err_code(err_code)
    );

    always #5 CLK = ~CLK;

    logic [15:0] rom [3];
    always @(posedge CLK) tbl_data <= rom[tbl_addr[1:0]];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scripted SCCB slave: ack 3 cycles after req, NACK on a chosen sub-address
    logic [7:0] resp_h, resp_l, nack_sub;
    int nack_limit = 0, nack_base = 0, nack_given = 0;
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.sccb_ack = 1'b0; bus.sccb_nack = 1'b0; bus.sccb_rdata = 8'h00;
        forever begin
            @(posedge CLK); #1;
            if (bus.sccb_ack) begin
                bus.sccb_ack = 1'b0; bus.sccb_nack = 1'b0; bus.sccb_rdata = 8'h00;
            end else if (bus.sccb_req) begin
                if (wait_cnt == 2) begin
                    wait_cnt = 0;
                    bus.sccb_ack = 1'b1;
                    if (bus.sccb_sub == nack_sub && (nack_given - nack_base) < nack_limit) begin
                        bus.sccb_nack = 1'b1;
                        nack_given++;
                    end
                    bus.sccb_rdata = (bus.sccb_sub == 8'h0A) ? resp_h :
                                     (bus.sccb_sub == 8'h0B) ? resp_l : 8'h00;
                end else wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    // Monitor: request log and power-up phase cycle counters
    logic [16:0] req_log [$];
    int n_pwdn = 0, n_rst = 0, n_wake = 0;
    initial begin
        logic req_prev, in_wait;
        req_prev = 1'b0; in_wait = 1'b1;
        forever begin
            @(negedge CLK);
            if (bus.sccb_req && !req_prev) req_log.push_back({bus.sccb_rw, bus.sccb_sub, bus.sccb_wdata});
            req_prev = bus.sccb_req;
            if (!busy) in_wait = 1'b1;
            if (bus.sccb_req) in_wait = 1'b0;
            if (busy && OV_PWDN) n_pwdn++;
            if (busy && !OV_PWDN && !OV_RST) n_rst++;
            if (busy && OV_RST && !bus.sccb_req && in_wait) n_wake++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [7:0]  id_h, id_l, nsub;
        int          ncnt;
        logic [15:0] t0, t1, t2;
        logic        exp_done, exp_idok, exp_err;
        logic [1:0]  exp_code;
        logic [7:0]  exp_addr;
        int          exp_nreq, exp_nwr;
        logic [7:0][15:0] exp_wr;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [7:0] h, l, ns, input int nc,
                                input logic [15:0] a, b, c, input logic d, ok, e,
                                input logic [1:0] code, input logic [7:0] addr,
                                input int nreq, nwr, input logic [127:0] wr);
        vec_t v;
        v.name = n; v.id_h = h; v.id_l = l; v.nsub = ns; v.ncnt = nc;
        v.t0 = a; v.t1 = b; v.t2 = c;
        v.exp_done = d; v.exp_idok = ok; v.exp_err = e; v.exp_code = code;
        v.exp_addr = addr; v.exp_nreq = nreq; v.exp_nwr = nwr; v.exp_wr = wr;
        return v;
    endfunction

    task automatic do_reset();
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 3000) begin @(negedge CLK); k++; end
        chk({nm, "_idle_timeout"}, busy, 0);
    endtask

    task automatic setup(input logic [15:0] a, b, c, input logic [7:0] h, l, ns, input int nc);
        rom[0] = a; rom[1] = b; rom[2] = c;
        resp_h = h; resp_l = l; nack_sub = ns;
        nack_base = nack_given; nack_limit = nc;
    endtask

    task automatic run_vec(input vec_t v);
        int base, p0, r0, w0, k;
        do_reset();
        setup(v.t0, v.t1, v.t2, v.id_h, v.id_l, v.nsub, v.ncnt);
        base = req_log.size(); p0 = n_pwdn; r0 = n_rst; w0 = n_wake;
        pulse_start();
        wait_idle(v.name);
        chk({v.name, "_done"}, done, v.exp_done);
        chk({v.name, "_id_ok"}, id_ok, v.exp_idok);
        chk({v.name, "_err"}, err, v.exp_err);
        chk({v.name, "_err_code"}, err_code, v.exp_code);
        chk({v.name, "_tbl_addr"}, tbl_addr, v.exp_addr);
        chk({v.name, "_nreq"}, req_log.size() - base, v.exp_nreq);
        chk({v.name, "_pwdn_cycles"}, n_pwdn - p0, 4);
        chk({v.name, "_rst_cycles"}, n_rst - r0, 4);
        chk({v.name, "_wake_cycles"}, n_wake - w0, 4);
        k = 0;
        for (int i = base; i < req_log.size(); i++) begin
            if (!req_log[i][16]) begin
                if (k < 8) chk($sformatf("%s_wr%0d", v.name, k), req_log[i][15:0], v.exp_wr[k]);
                k++;
            end
        end
        chk({v.name, "_nwr"}, k, v.exp_nwr);
        $display("vec %s: done=%0d id_ok=%0d err=%0d code=%0d addr=%0d reqs=%0d",
                 v.name, done, id_ok, err, err_code, tbl_addr, req_log.size() - base);
    endtask

    task automatic settle_run(input string nm, input logic [15:0] mid, input int exp_gap);
        int k, g;
        do_reset();
        setup(16'h2001, mid, 16'h2102, 8'h76, 8'h73, 8'hFF, 0);
        pulse_start();
        k = 0;
        while (!(bus.sccb_ack && bus.sccb_req && bus.sccb_sub == 8'h12) && k < 3000) begin
            @(negedge CLK); k++;
        end
        chk({nm, "_ack_seen"}, (k < 3000), 1);
        g = 0;
        while (tbl_addr != 8'd2 && g < 100) begin @(negedge CLK); g++; end
        chk({nm, "_gap"}, g, exp_gap);
        wait_idle(nm);
        chk({nm, "_done"}, done, 1);
        $display("settle %s: gap=%0d done=%0d", nm, g, done);
    endtask

    vec_t vecs[6];

    initial begin
        int k, base;
        vecs[0] = mk("normal",      8'h76, 8'h73, 8'hFF, 0,   16'h2001, 16'h2102, 16'h2203,
                     1, 1, 0, 2'b00, 8'd2, 5, 3, 128'({16'h2203, 16'h2102, 16'h2001}));
        vecs[1] = mk("id_low_bad",  8'h76, 8'h00, 8'hFF, 0,   16'h2001, 16'h2102, 16'h2203,
                     0, 0, 1, 2'b10, 8'd0, 2, 0, 128'd0);
        vecs[2] = mk("wr_nack2",    8'h76, 8'h73, 8'h20, 2,   16'h2001, 16'h2102, 16'h2203,
                     1, 1, 0, 2'b00, 8'd2, 7, 5,
                     128'({16'h2203, 16'h2102, 16'h2001, 16'h2001, 16'h2001}));
        vecs[3] = mk("wr_nack_all", 8'h76, 8'h73, 8'h21, 100, 16'h2001, 16'h2102, 16'h2203,
                     0, 1, 1, 2'b01, 8'd1, 7, 5,
                     128'({16'h2102, 16'h2102, 16'h2102, 16'h2102, 16'h2001}));
        vecs[4] = mk("id_high_bad", 8'h00, 8'h73, 8'hFF, 0,   16'h2001, 16'h2102, 16'h2203,
                     0, 0, 1, 2'b10, 8'd0, 2, 0, 128'd0);
        vecs[5] = mk("rd_nack_all", 8'h76, 8'h73, 8'h0A, 100, 16'h2001, 16'h2102, 16'h2203,
                     0, 0, 1, 2'b01, 8'd0, 4, 0, 128'd0);

        // Reset values while RST_n is held low
        @(negedge CLK);
        chk("reset_ctrl", {OV_PWDN, OV_RST, bus.sccb_req, bus.sccb_rw, busy, done, id_ok, err, err_code},
            10'b10_0000_0000);
        chk("reset_bus", {bus.sccb_sub, bus.sccb_wdata, tbl_addr}, 24'd0);
        $display("reset: OV_PWDN=%0d OV_RST=%0d busy=%0d", OV_PWDN, OV_RST, busy);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        settle_run("soft_rst", 16'h1280, 10);
        settle_run("no_soft_rst", 16'h1200, 2);

        // Asynchronous reset in the middle of the write of entry 1
        do_reset();
        setup(16'h2001, 16'h2102, 16'h2203, 8'h76, 8'h73, 8'hFF, 0);
        pulse_start();
        k = 0;
        while (!(bus.sccb_req && !bus.sccb_rw && tbl_addr == 8'd1) && k < 3000) begin
            @(negedge CLK); k++;
        end
        chk("midrst_wr_seen", (k < 3000), 1);
        RST_n = 1'b0;
        #1;
        chk("midrst_pins", {OV_PWDN, OV_RST, bus.sccb_req, busy}, 4'b1000);
        chk("midrst_addr", tbl_addr, 0);
        @(negedge CLK) RST_n = 1'b1;
        repeat (3) @(negedge CLK);
        chk("midrst_idle", busy, 0);
        base = req_log.size();
        pulse_start();
        k = 0;
        while (!(bus.sccb_req && !bus.sccb_rw) && k < 3000) begin @(negedge CLK); k++; end
        chk("restart_first_wr", {bus.sccb_sub, bus.sccb_wdata}, 16'h2001);
        chk("restart_addr", tbl_addr, 0);
        wait_idle("restart");
        chk("restart_done", done, 1);
        chk("restart_nreq", req_log.size() - base, 5);
        $display("restart: done=%0d addr=%0d reqs=%0d", done, tbl_addr, req_log.size() - base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
